zigzag_reorder: RTL and testbench
=================================

# zigzag_reorder

Streaming, parametrised 8x8 coefficient reorder buffer that replaces the flat 2048-bit parallel inverse-zigzag stage. It accepts one coefficient per cycle over a valid/ready handshake and emits the same block permuted, either raster->zigzag (forward) or zigzag->raster (inverse). Mode is selectable per block. Two ping-pong banks let the next block fill while the previous one drains. It sits between the entropy decoder/dequantiser and the IDCT, or mirrored on the encode path.

## Interface
- DW, 32, coefficient width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input coefficient valid
- in_ready  out  1  buffer can accept a coefficient this cycle
- in_data  in  DW  coefficient; block order is index 0..63
- in_inverse  in  1  mode for the block; sampled only on its first accepted beat (1 = zigzag->raster, 0 = raster->zigzag)
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  reordered coefficient
- out_last  out  1  high on the 64th beat of a block
- busy  out  1  either bank is non-empty

## Operation
- Storage is two banks of 64 x DW, register or distributed RAM. Each bank has a state of EMPTY, FILLING, FULL or DRAINING, plus a latched mode bit.
- Write side: a 6-bit wr_cnt and a 1-bit wr_bank. An accepted beat (in_valid & in_ready) writes bank[wr_bank][wr_cnt].
  - On wr_cnt==0 the bank goes EMPTY->FILLING and latches in_inverse.
  - On wr_cnt==63 the bank goes to FULL, wr_cnt wraps to 0 and wr_bank toggles.
- in_ready = (bank[wr_bank] is EMPTY or FILLING).
- Read side: a 6-bit rd_cnt and a 1-bit rd_bank. The read address comes from a 64-entry constant table.
  - Forward mode: addr = ZZ[rd_cnt], the raster index of the k-th zigzag position (0,1,8,16,9,2,3,10,17,24,...,63).
  - Inverse mode: addr = IZZ[rd_cnt], the zigzag position of raster index k (0,1,5,6,14,15,27,28,2,4,...,63).
  - The tables are generated by a function or constant; the mapping uses the standard JPEG zigzag.
- Bank FULL -> DRAINING when it becomes the read bank.
  - Each accepted output beat (out_valid & out_ready) increments rd_cnt.
  - On rd_cnt==63 the bank goes to EMPTY, rd_cnt wraps and rd_bank toggles.
- Simultaneous events: a bank drained to EMPTY in cycle t may start FILLING in cycle t+1, never in the same cycle. A write to one bank and a read from the other in the same cycle is always legal.
- busy = any bank not EMPTY.

## Timing
- Reset (rst high at a clk edge) sets:
  - all banks to EMPTY
  - wr_cnt, rd_cnt, wr_bank and rd_bank to 0
  - out_valid=0, out_last=0, out_data=0, busy=0
  - in_ready goes to 1 on the first cycle after reset deasserts.
- Reset mid-block discards all buffered data and partial blocks. Bank contents need not be cleared.
- Output is registered. out_valid rises 2 cycles after the edge accepting beat 63 of a block: one edge for FULL, one edge for the registered read.
- Drain throughput is 1 beat/cycle while out_ready=1. The output side keeps a one-entry skid/prefetch so there are no bubbles inside a block.
- Sustained throughput is 64 beats per 64 cycles, with no gap between blocks when both sides run continuously.
- Backpressure: while out_valid & !out_ready, out_data and out_last hold stable and rd_cnt does not advance.
- in_ready drops the cycle after both banks are non-EMPTY/FILLING, i.e. when the write bank becomes FULL and the other bank is FULL or DRAINING.
- in_inverse on non-first beats is ignored.

## Configuration
- ZIGZAG_REORDER_STATS_EN defined:
  - Adds output port blk_count (16 bits, reset 0).
  - blk_count increments on every out_last handshake and wraps 0xFFFF->0.
  - Adds output overflow_sticky (1 bit, reset 0), set when in_valid is high while in_ready is low.
- Not defined: neither port exists. Datapath behaviour is identical.

## Test plan
- Forward, in_data=k for k=0..63, out_ready=1 -> outputs 0,1,8,16,9,2,3,10,17,24,...,63. out_last on beat 64. First out_valid 2 cycles after beat 63.
- Inverse, in_data=k -> outputs 0,1,5,6,14,15,27,28,2,4,...,62,63. Applying forward then inverse to any random block returns the original block.
- Back-to-back: 4 blocks with alternating mode, out_ready=1 -> 256 contiguous output beats, each block in its own latched mode, no idle cycles between blocks.
- Backpressure: out_ready=0 for 200 cycles after the first output -> out_data holds, in_ready=0 after the second block fills, no data lost or duplicated once released.
- Reset asserted at input beat 30 of block 1 while block 0 drains at rd_cnt=10 -> next cycle out_valid=0 and busy=0. A fresh block after reset outputs correctly.
- With ZIGZAG_REORDER_STATS_EN: 3 blocks -> blk_count=3. Driving in_valid while in_ready=0 sets overflow_sticky=1, which holds until rst.

Source files
------------

// File: rtl/zigzag_reorder_if.sv
// Coefficient stream interface for zigzag_reorder: input beat stream with a
// per-block mode bit, and the reordered output stream with an end-of-block flag.
interface zigzag_reorder_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_inverse;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, in_inverse, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_inverse, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/zigzag_reorder.sv
// Streaming 8x8 ping-pong reorder buffer: raster->zigzag or zigzag->raster per block.
// Optional ZIGZAG_REORDER_STATS_EN adds blk_count and overflow_sticky outputs.
module zigzag_reorder #(
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    zigzag_reorder_if.slave  io,
    output logic             busy
`ifdef ZIGZAG_REORDER_STATS_EN
    ,
    output logic [15:0]      blk_count,
    output logic             overflow_sticky
`endif
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    // Walk the 15 anti-diagonals of the 8x8 block; even diagonals run up-right.
    function automatic logic [383:0] gen_zz();
        logic [383:0] t;
        int k, r, c;
        t = '0;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < 8; i++) begin
                r = (s % 2 == 0) ? ((s < 8 ? s : 7) - i) : ((s < 8 ? 0 : s - 7) + i);
                c = s - r;
                if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
                    t[k*6 +: 6] = 6'(r * 8 + c);
                    k++;
                end
            end
        end
        return t;
    endfunction

    function automatic logic [383:0] gen_izz();
        logic [383:0] zz, t;
        int a;
        zz = gen_zz();
        t  = '0;
        for (int k = 0; k < 64; k++) begin
            a = int'(zz[k*6 +: 6]);
            t[a*6 +: 6] = 6'(k);
        end
        return t;
    endfunction

    function automatic logic [5:0] tbl_at(input logic [383:0] tbl, input logic [5:0] idx);
        return tbl[idx*6 +: 6];
    endfunction

    localparam logic [383:0] ZZ_TBL  = gen_zz();
    localparam logic [383:0] IZZ_TBL = gen_izz();

    logic [DW-1:0] bank_mem_q [2][64];
    bank_state_e   state_q [2], state_d [2];
    logic          mode_q  [2], mode_d  [2];
    logic [5:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic          pf_valid_q, pf_valid_d, pf_last_q, pf_last_d;
    logic [DW-1:0] pf_data_q, pf_data_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          in_ready_w, rd_avail, wr_fire, out_fire, out_load, rd_fire;
    logic [5:0]    rd_addr;
`ifdef ZIGZAG_REORDER_STATS_EN
    logic [15:0]   blk_count_q, blk_count_d;
    logic          overflow_q, overflow_d;
`endif

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                mode_q[b]  <= 1'b0;
            end
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            pf_valid_q  <= 1'b0;
            pf_last_q   <= 1'b0;
            pf_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
`ifdef ZIGZAG_REORDER_STATS_EN
            blk_count_q <= '0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            pf_valid_q  <= pf_valid_d;
            pf_last_q   <= pf_last_d;
            pf_data_q   <= pf_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
`ifdef ZIGZAG_REORDER_STATS_EN
            blk_count_q <= blk_count_d;
            overflow_q  <= overflow_d;
`endif
        end
    end

    // NOTE: the coefficient storage has no reset; bank state alone marks data as stale.
    always_ff @(posedge clk) begin
        if (wr_fire) bank_mem_q[wr_bank_q][wr_cnt_q] <= io.in_data;
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        pf_valid_d  = pf_valid_q;
        pf_last_d   = pf_last_q;
        pf_data_d   = pf_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING.
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd0) begin
                state_d[wr_bank_q] = FILLING;
                mode_d[wr_bank_q]  = io.in_inverse;
            end
            if (wr_cnt_q == 6'd63) begin
                state_d[wr_bank_q] = FULL;
                wr_bank_d          = ~wr_bank_q;
            end
        end

        if (state_q[rd_bank_q] == FULL) state_d[rd_bank_q] = DRAINING;
        if (rd_fire) begin
            rd_cnt_d  = rd_cnt_q + 6'd1;
            pf_data_d = bank_mem_q[rd_bank_q][rd_addr];
            pf_last_d = (rd_cnt_q == 6'd63);
            if (rd_cnt_q == 6'd63) begin
                state_d[rd_bank_q] = EMPTY;
                rd_bank_d          = ~rd_bank_q;
            end
        end

        if (rd_fire)       pf_valid_d = 1'b1;
        else if (out_load) pf_valid_d = 1'b0;

        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = pf_data_q;
            out_last_d  = pf_last_q;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Prefetch stage plus output register form a two-entry skid, so a bank
    // empties as soon as its last entry is read and the next block starts bubble-free.
    always_comb begin
        in_ready_w = !rst && (state_q[wr_bank_q] == EMPTY || state_q[wr_bank_q] == FILLING);
        busy       = (state_q[0] != EMPTY) || (state_q[1] != EMPTY);
        rd_avail   = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
        wr_fire    = io.in_valid && in_ready_w;
        out_fire   = out_valid_q && io.out_ready;
        out_load   = pf_valid_q && (!out_valid_q || io.out_ready);
        rd_fire    = rd_avail && (!pf_valid_q || out_load);
        rd_addr    = mode_q[rd_bank_q] ? tbl_at(IZZ_TBL, rd_cnt_q) : tbl_at(ZZ_TBL, rd_cnt_q);
    end

`ifdef ZIGZAG_REORDER_STATS_EN
    always_comb begin
        blk_count_d = blk_count_q;
        if (out_fire && out_last_q) blk_count_d = blk_count_q + 16'd1;
        overflow_d = overflow_q || (io.in_valid && !in_ready_w);
    end

    assign blk_count       = blk_count_q;
    assign overflow_sticky = overflow_q;
`endif

    assign io.in_ready  = in_ready_w;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_last  = out_last_q;
endmodule

// File: tb/tb_zigzag_reorder.sv
// Self-checking bench for zigzag_reorder: random blocks compared against a
// zigzag model derived from diagonal ordering rather than a table walk.
module tb_zigzag_reorder;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          inv;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef ZIGZAG_REORDER_STATS_EN
    logic [15:0] blk_count;
    logic        overflow_sticky;
`endif

    zigzag_reorder_if #(.DW(DW)) bus ();

    zigzag_reorder #(.DW(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .io   (bus),
        .busy (busy)
`ifdef ZIGZAG_REORDER_STATS_EN
        ,
        .blk_count       (blk_count),
        .overflow_sticky (overflow_sticky)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            zz_tbl [64];
    int            izz_tbl[64];
    beat_t         beat_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          got_last_q[$];
    int            got_cyc_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_last_q.push_back(bus.out_last);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Zigzag rank: diagonal first, then row ascending on odd diagonals, column ascending on even.
    function automatic int zkey(input int p);
        int r, c, s;
        r = p / 8;
        c = p % 8;
        s = r + c;
        return s * 16 + ((s % 2 == 1) ? r : c);
    endfunction

    function automatic void build_model();
        int rank;
        for (int p = 0; p < 64; p++) begin
            rank = 0;
            for (int q = 0; q < 64; q++) if (zkey(q) < zkey(p)) rank++;
            izz_tbl[p]    = rank;
            zz_tbl[rank] = p;
        end
    endfunction

    function automatic void clear_queues();
        beat_q.delete();
        exp_q.delete();
        got_q.delete();
        got_last_q.delete();
        got_cyc_q.delete();
    endfunction

    task automatic add_block(input logic [DW-1:0] d [64], input bit inv);
        beat_t b;
        for (int k = 0; k < 64; k++) begin
            b.data = d[k];
            b.inv  = (k == 0) ? inv : 1'($urandom);
            beat_q.push_back(b);
            exp_q.push_back(inv ? d[izz_tbl[k]] : d[zz_tbl[k]]);
        end
    endtask

    task automatic add_random_block(input bit inv);
        logic [DW-1:0] d [64];
        for (int k = 0; k < 64; k++) d[k] = $urandom;
        add_block(d, inv);
    endtask

    task automatic add_ramp_block(input bit inv);
        logic [DW-1:0] d [64];
        for (int k = 0; k < 64; k++) d[k] = DW'(k);
        add_block(d, inv);
    endtask

    task automatic set_out_ready(input logic v);
        @(posedge clk);
        #1 bus.out_ready = v;
    endtask

    // Feeds every queued beat; returns at the negedge after the last acceptance.
    task automatic drive_all(input int gap_pct, output int stalls, output bit ok);
        beat_t b;
        int    guard;
        ok     = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid   = 1'b1;
            bus.in_data    = b.data;
            bus.in_inverse = b.inv;
            guard = 0;
            while (!bus.in_ready && guard < 4000) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            if (guard >= 4000) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid   = 1'b0;
        bus.in_inverse = 1'($urandom);
    endtask

    task automatic wait_outputs(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        ok = (got_q.size() >= n);
        repeat (6) @(posedge clk);
    endtask

    task automatic sink_random(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk);
            #1 bus.out_ready = ($urandom_range(99) < 60);
            c++;
        end
        set_out_ready(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic test_reset();
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_inverse = 1'b0;
        bus.out_ready  = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_flags: valid %b last %b expected 0 0", bus.out_valid, bus.out_last);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        clear_queues();
    endtask

    task automatic test_forward();
        int  fwd_ref [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
        int  stalls;
        bit  ok;
        logic [2:0] vseq;
        set_out_ready(1'b1);
        add_ramp_block(1'b0);
        drive_all(0, stalls, ok);
        vseq[2] = bus.out_valid;
        @(negedge clk) vseq[1] = bus.out_valid;
        @(negedge clk) vseq[0] = bus.out_valid;
        checks++;
        if (!ok || vseq !== 3'b001) begin
            errors++; $display("FAIL fwd_latency: out_valid over 3 cycles %b expected 001 (drive ok %b)", vseq, ok);
        end
        wait_outputs(64, 300, ok);
        checks++;
        if (got_q.size() != 64) begin
            errors++; $display("FAIL fwd_count: got %0d beats expected 64", got_q.size());
        end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== DW'(fwd_ref[i])) begin
                errors++; $display("FAIL fwd_prefix[%0d]: got %0d expected %0d", i, got_q[i], fwd_ref[i]);
            end
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 63)) begin
                errors++; $display("FAIL fwd_beat[%0d]: got %0d last %b expected %0d last %b",
                                   i, got_q[i], got_last_q[i], exp_q[i], (i == 63));
            end
        end
        clear_queues();
    endtask

    task automatic test_inverse();
        int            inv_ref [10] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4};
        logic [DW-1:0] orig [64];
        logic [DW-1:0] fwd_out [64];
        int            stalls;
        bit            ok;
        add_ramp_block(1'b1);
        drive_all(0, stalls, ok);
        wait_outputs(64, 300, ok);
        checks++;
        if (got_q.size() != 64) begin
            errors++; $display("FAIL inv_count: got %0d beats expected 64", got_q.size());
        end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== DW'(inv_ref[i])) begin
                errors++; $display("FAIL inv_prefix[%0d]: got %0d expected %0d", i, got_q[i], inv_ref[i]);
            end
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 63)) begin
                errors++; $display("FAIL inv_beat[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
            end
        end
        clear_queues();

        // Round trip: forward a random block, feed the result back inverse.
        for (int k = 0; k < 64; k++) orig[k] = $urandom;
        add_block(orig, 1'b0);
        drive_all(0, stalls, ok);
        wait_outputs(64, 300, ok);
        for (int k = 0; k < 64; k++) fwd_out[k] = (k < got_q.size()) ? got_q[k] : '0;
        clear_queues();
        add_block(fwd_out, 1'b1);
        drive_all(0, stalls, ok);
        wait_outputs(64, 300, ok);
        checks++;
        if (got_q.size() != 64) begin
            errors++; $display("FAIL roundtrip_count: got %0d beats expected 64", got_q.size());
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== orig[i]) begin
                errors++; $display("FAIL roundtrip[%0d]: got %h expected %h", i, got_q[i], orig[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        int stalls;
        bit ok, contiguous;
        for (int b = 0; b < 4; b++) add_random_block(1'(b % 2));
        drive_all(0, stalls, ok);
        wait_outputs(256, 600, ok);
        checks++;
        if (!ok || stalls != 0) begin
            errors++; $display("FAIL b2b_input_stalls: got %0d stall cycles expected 0", stalls);
        end
        checks++;
        if (got_q.size() != 256) begin
            errors++; $display("FAIL b2b_count: got %0d beats expected 256", got_q.size());
        end
        contiguous = (got_q.size() == 256);
        for (int i = 1; i < got_cyc_q.size(); i++)
            if (got_cyc_q[i] != got_cyc_q[0] + i) contiguous = 1'b0;
        checks++;
        if (!contiguous) begin
            errors++; $display("FAIL b2b_contiguous: output beats not on consecutive cycles, span %0d",
                               got_cyc_q.size() > 0 ? got_cyc_q[got_cyc_q.size()-1] - got_cyc_q[0] : -1);
        end
        for (int i = 0; i < 256 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % 64 == 63)) begin
                errors++; $display("FAIL b2b_beat[%0d]: got %h last %b expected %h last %b",
                                   i, got_q[i], got_last_q[i], exp_q[i], (i % 64 == 63));
            end
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        int            stalls;
        bit            ok_d, ok_o, stable, seen;
        logic [DW-1:0] held;
        logic          held_last;
        int            c;
        set_out_ready(1'b0);
        for (int b = 0; b < 3; b++) add_random_block(1'($urandom));
        fork
            drive_all(0, stalls, ok_d);
            begin
                c = 0;
                @(negedge clk);
                while (!bus.out_valid && c < 400) begin
                    @(negedge clk);
                    c++;
                end
                seen      = bus.out_valid;
                held      = bus.out_data;
                held_last = bus.out_last;
                stable    = 1'b1;
                repeat (200) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_last !== held_last)
                        stable = 1'b0;
                end
                checks++;
                if (!seen || !stable) begin
                    errors++; $display("FAIL bp_hold: seen %b stable %b data now %h expected %h",
                                       seen, stable, bus.out_data, held);
                end
                checks++;
                if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL bp_in_ready: in_ready %b busy %b expected 0 1", bus.in_ready, busy);
                end
                set_out_ready(1'b1);
            end
        join
        wait_outputs(192, 600, ok_o);
        checks++;
        if (!ok_d || got_q.size() != 192) begin
            errors++; $display("FAIL bp_count: got %0d beats expected 192 (drive ok %b)", got_q.size(), ok_d);
        end
        for (int i = 0; i < 192 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % 64 == 63)) begin
                errors++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_random_flow();
        int stalls;
        bit ok;
        for (int b = 0; b < 5; b++) add_random_block(1'($urandom));
        fork
            drive_all(30, stalls, ok);
            sink_random(320, 4000);
        join
        wait_outputs(320, 300, ok);
        checks++;
        if (got_q.size() != 320) begin
            errors++; $display("FAIL rand_count: got %0d beats expected 320", got_q.size());
        end
        for (int i = 0; i < 320 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % 64 == 63)) begin
                errors++; $display("FAIL rand_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_reset_mid_block();
        logic [DW-1:0] d [64];
        beat_t         b;
        int            stalls;
        bit            ok;
        set_out_ready(1'b1);
        add_random_block(1'b0);
        for (int k = 0; k < 31; k++) begin
            b.data = $urandom;
            b.inv  = 1'($urandom);
            beat_q.push_back(b);
        end
        drive_all(0, stalls, ok);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== '0) begin
            errors++; $display("FAIL midrst_outputs: valid %b busy %b last %b data %h expected 0 0 0 0",
                               bus.out_valid, busy, bus.out_last, bus.out_data);
        end
        rst = 1'b0;
        clear_queues();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready);
        end
        for (int k = 0; k < 64; k++) d[k] = $urandom;
        add_block(d, 1'b1);
        drive_all(0, stalls, ok);
        wait_outputs(64, 300, ok);
        checks++;
        if (got_q.size() != 64) begin
            errors++; $display("FAIL midrst_count: got %0d beats expected 64", got_q.size());
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL midrst_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        clear_queues();
    endtask

`ifdef ZIGZAG_REORDER_STATS_EN
    task automatic test_stats();
        int stalls;
        bit ok;
        set_out_ready(1'b1);
        do_reset();
        checks++;
        if (blk_count !== 16'd0 || overflow_sticky !== 1'b0) begin
            errors++; $display("FAIL stats_reset: blk_count %0d sticky %b expected 0 0", blk_count, overflow_sticky);
        end
        for (int b = 0; b < 3; b++) add_random_block(1'($urandom));
        drive_all(0, stalls, ok);
        wait_outputs(192, 600, ok);
        checks++;
        if (blk_count !== 16'd3) begin
            errors++; $display("FAIL stats_blk_count: got %0d expected 3", blk_count);
        end
        clear_queues();
        set_out_ready(1'b0);
        for (int b = 0; b < 2; b++) add_random_block(1'b0);
        drive_all(0, stalls, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (overflow_sticky !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stats_pre_overflow: sticky %b in_ready %b expected 0 0", overflow_sticky, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (overflow_sticky !== 1'b1) begin
            errors++; $display("FAIL stats_overflow: got %b expected 1", overflow_sticky);
        end
        do_reset();
        checks++;
        if (overflow_sticky !== 1'b0 || blk_count !== 16'd0) begin
            errors++; $display("FAIL stats_clear: sticky %b blk_count %0d expected 0 0", overflow_sticky, blk_count);
        end
        set_out_ready(1'b1);
        repeat (4) @(negedge clk);
        clear_queues();
    endtask
`endif

    initial begin
        build_model();
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_random_flow();
`ifdef ZIGZAG_REORDER_STATS_EN
        test_stats();
`endif
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
